// File: rtl/packet_collect_pkg.sv
// Shared definitions for the packet_collect block: drain FSM encoding and
// the address-width helper used to size the buffer and counters.
package packet_collect_pkg;

  typedef enum logic [1:0] {
    COLLECT   = 2'b00,
    DRAIN_REQ = 2'b01,
    DRAIN     = 2'b10
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/packet_collect_buffer.sv
// Simple dual-port packet store: one write port, one registered read port.
// Storage is deliberately left unreset; readers qualify data with their own valid.
module packet_buffer
  import packet_collect_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read data holds while i_rd_en is low, so it doubles as a pipeline stage.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/packet_collect.sv
// Collects RANC output packets per timestep frame and, on tick, drains the
// frame as an AXI-stream burst with tlast on the final word.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   COLLECT   | accept packets into the buffer until tick
//   DRAIN_REQ | first buffer read issued, nothing on the stream yet
//   DRAIN     | stream words out until the tlast handshake
module packet_collect
  import packet_collect_pkg::*;
#(
  parameter  int NUMBER_OF_OUTPUT_WORDS = 32,
  parameter  int PACKET_WIDTH           = 32,
  localparam int addr_bits              = clogb2(NUMBER_OF_OUTPUT_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    packet_in_valid,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  output logic                    packet_in_ready,
  output logic                    m_axis_tvalid,
  output logic [PACKET_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [addr_bits:0]      num_packets,
  output logic                    drain_overrun
);

  localparam int COUNT_W = addr_bits + 1;
  localparam int ADDR_W  = (addr_bits < 1) ? 1 : addr_bits;
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(NUMBER_OF_OUTPUT_WORDS);
  localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);

  state_t r_state;
  state_t w_next_state;

  logic [COUNT_W-1:0]      r_wr_count;
  logic [COUNT_W-1:0]      r_rd_addr;
  logic [COUNT_W-1:0]      r_num_packets;
  logic [COUNT_W-1:0]      w_count_next;
  logic                    r_rst_done;
  logic                    r_rd_valid;
  logic                    r_rd_last;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic [PACKET_WIDTH-1:0] r_tdata;
  logic                    r_overrun;
  logic [PACKET_WIDTH-1:0] w_rd_data;

  logic w_collect;
  logic w_draining;
  logic w_in_ready;
  logic w_wr_en;
  logic w_out_free;
  logic w_load_out;
  logic w_rd_en;
  logic w_last_hs;

  assign w_collect    = (r_state == COLLECT);
  assign w_draining   = (r_state == DRAIN_REQ) || (r_state == DRAIN);
  assign w_in_ready   = r_rst_done && w_collect && (r_wr_count < DEPTH_C);
  assign w_wr_en      = packet_in_valid && w_in_ready;
  // A transfer on the tick cycle still belongs to the closing frame.
  assign w_count_next = w_wr_en ? (r_wr_count + ONE_C) : r_wr_count;

  // Two-stage drain: buffer read register feeds the output holding register.
  assign w_out_free = !r_tvalid || m_axis_tready;
  assign w_load_out = r_rd_valid && w_out_free;
  assign w_rd_en    = w_draining && (r_rd_addr < r_num_packets) &&
                      (!r_rd_valid || w_load_out);
  assign w_last_hs  = r_tvalid && r_tlast && m_axis_tready;

  packet_buffer #(
    .DEPTH  (NUMBER_OF_OUTPUT_WORDS),
    .WIDTH  (PACKET_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_count[ADDR_W-1:0]),
    .i_wr_data (packet_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT:   if (tick && (w_count_next != '0)) w_next_state = DRAIN_REQ;
      DRAIN_REQ: w_next_state = DRAIN;
      DRAIN:     if (w_last_hs) w_next_state = COLLECT;
      default:   w_next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done    <= 1'b0;
      r_wr_count    <= '0;
      r_num_packets <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_last_hs)    r_wr_count <= '0;
      else if (w_wr_en) r_wr_count <= w_count_next;
      if (w_collect && tick)  r_num_packets <= w_count_next;
      if (w_draining && tick) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_collect)    r_rd_addr <= '0;
      else if (w_rd_en) r_rd_addr <= r_rd_addr + ONE_C;
      if (w_rd_en) begin
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_rd_addr == (r_num_packets - ONE_C));
      end else if (w_load_out) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Output holding register: only reloads when empty or being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_load_out) begin
      r_tvalid <= 1'b1;
      r_tlast  <= r_rd_last;
      r_tdata  <= w_rd_data;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign packet_in_ready = w_in_ready;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tdata    = r_tdata;
  assign m_axis_tlast    = r_tlast;
  assign num_packets     = r_num_packets;
  assign drain_overrun   = r_overrun;

endmodule

// File: tb/tb_packet_collect.sv
// Randomized frame-level bench for packet_collect against a queue-based model.
`timescale 1ns/1ps
module tb_packet_collect;

  localparam int DEPTH = 32;
  localparam int W     = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          packet_in_valid = 1'b0;
  logic [W-1:0]  packet_in = '0;
  logic          packet_in_ready;
  logic          m_axis_tvalid;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] num_packets;
  logic          drain_overrun;

  packet_collect #(
    .NUMBER_OF_OUTPUT_WORDS (DEPTH),
    .PACKET_WIDTH           (W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .packet_in_valid (packet_in_valid),
    .packet_in       (packet_in),
    .packet_in_ready (packet_in_ready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .num_packets     (num_packets),
    .drain_overrun   (drain_overrun)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fixed_q[$];
  bit           rdy_pat[$];
  int           exp_cnt = 0;
  bit           exp_overrun = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'(0));
    chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(0));
    chk({tag, "_ready"}, 64'(packet_in_ready), 64'(0));
    chk({tag, "_num"}, 64'(num_packets), 64'(0));
    chk({tag, "_ovr"}, 64'(drain_overrun), 64'(0));
  endtask

  // Release reset at a negedge; ready must wait for the first rising edge.
  task automatic release_reset();
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(packet_in_ready), 64'(0));
    @(negedge clk);
    chk("ready_after_edge", 64'(packet_in_ready), 64'(1));
  endtask

  // n_cyc ordinary cycles, then one tick cycle (optionally carrying a packet).
  task automatic collect(input int n_cyc, input int v_pct, input bit tick_pkt);
    bit           v;
    bit           er;
    logic [W-1:0] d;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i <= n_cyc; i++) begin
      er = (exp_cnt < DEPTH);
      chk("in_ready", 64'(packet_in_ready), 64'(er));
      v = (i == n_cyc) ? tick_pkt : ($urandom_range(99) < v_pct);
      if (v && fixed_q.size() > 0) d = fixed_q.pop_front();
      else d = $urandom;
      packet_in_valid = v;
      packet_in       = d;
      tick            = (i == n_cyc);
      if (v && er) begin
        exp_q.push_back(d);
        exp_cnt++;
      end
      @(negedge clk);
    end
    tick            = 1'b0;
    packet_in_valid = 1'b0;
    chk("num_packets", 64'(num_packets), 64'(exp_cnt));
  endtask

  task automatic check_empty();
    for (int i = 0; i < 4; i++) begin
      chk("empty_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("empty_ready", 64'(packet_in_ready), 64'(1));
      @(negedge clk);
    end
  endtask

  // Entered at the first negedge after the closing tick edge.
  task automatic drain(input int rdy_pct, input int tick_at);
    int           idx = 0;
    int           k = 0;
    int           first_k = -1;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    bit           prev_last = 1'b0;
    bit           r;
    while (idx < exp_cnt && k < 400) begin
      chk("drain_in_ready", 64'(packet_in_ready), 64'(0));
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
        chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
        chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && first_k < 0) first_k = k;
      if (m_axis_tvalid && rdy_pat.size() > 0) r = rdy_pat.pop_front();
      else r = ($urandom_range(99) < rdy_pct);
      m_axis_tready   = r;
      packet_in_valid = $urandom_range(1);
      packet_in       = $urandom;
      tick            = (k == tick_at);
      if (tick) exp_overrun = 1'b1;
      if (m_axis_tvalid && r) begin
        chk("word", 64'(m_axis_tdata), 64'(exp_q[idx]));
        chk("tlast", 64'(m_axis_tlast), 64'(idx == exp_cnt - 1));
        idx++;
      end
      prev_stall = m_axis_tvalid && !r;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      @(negedge clk);
      k++;
    end
    tick            = 1'b0;
    packet_in_valid = 1'b0;
    chk("drain_words", 64'(idx), 64'(exp_cnt));
    chk("first_valid_latency_ok", 64'(first_k >= 0 && first_k <= 2), 64'(1));
    chk("tvalid_drop", 64'(m_axis_tvalid), 64'(0));
    chk("ready_back", 64'(packet_in_ready), 64'(1));
    chk("overrun", 64'(drain_overrun), 64'(exp_overrun));
  endtask

  task automatic reset_mid_drain();
    int seen = 0;
    int k = 0;
    collect(6, 100, 1'b0);
    m_axis_tready = 1'b1;
    while (seen < 2 && k < 20) begin
      if (m_axis_tvalid) begin
        chk("pre_rst_word", 64'(m_axis_tdata), 64'(exp_q[seen]));
        seen++;
      end
      @(negedge clk);
      k++;
    end
    chk("pre_rst_words", 64'(seen), 64'(2));
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    exp_overrun = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_tvalid", 64'(m_axis_tvalid), 64'(0));
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_stream", 64'(m_axis_tvalid), 64'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    release_reset();

    m_axis_tready = 1'b1;
    fixed_q = '{32'hA1, 32'hA2, 32'hA3};
    collect(3, 100, 1'b0);
    drain(100, -1);

    collect(0, 0, 1'b0);
    check_empty();

    fixed_q = '{32'hB1, 32'hB2};
    collect(1, 100, 1'b1);
    drain(100, -1);

    collect(40, 100, 1'b0);
    drain(100, -1);

    collect(4, 100, 1'b0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    drain(100, -1);

    for (int f = 0; f < 10; f++) begin
      collect($urandom_range(45), $urandom_range(100, 20), 1'($urandom_range(1)));
      if (exp_cnt == 0) check_empty();
      else drain($urandom_range(100, 30), -1);
    end

    collect(5, 100, 1'b0);
    drain(60, 3);
    collect(3, 100, 1'b0);
    drain(100, -1);

    reset_mid_drain();
    fixed_q = '{32'hC1, 32'hC2, 32'hC3};
    collect(3, 100, 1'b0);
    drain(100, -1);

    for (int f = 0; f < 4; f++) begin
      collect($urandom_range(36, 1), 100, 1'b0);
      drain($urandom_range(100, 40), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_collect.md
PACKET_COLLECT -- requirements
Module: packet_collect

Interface
REQ-001 Parameter NUMBER_OF_OUTPUT_WORDS, default 32, SHALL set the depth of the output packet buffer in words.
REQ-002 Parameter PACKET_WIDTH, default 32, SHALL set the width of one RANC output packet and of the stream data bus.
REQ-003 Derived constant addr_bits SHALL equal ceil(log2(NUMBER_OF_OUTPUT_WORDS)); count width SHALL be addr_bits+1.
REQ-004 clk  input  1  the single clock; all state SHALL change on its rising edge, except on reset.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-cycle RANC timestep pulse that closes the current collection frame.
REQ-007 packet_in_valid  input  1  RANC output packet present.
REQ-008 packet_in  input  PACKET_WIDTH  RANC output packet data.
REQ-009 packet_in_ready  output  1  block accepts packet_in this cycle.
REQ-010 m_axis_tvalid  output  1  stream word valid.
REQ-011 m_axis_tdata  output  PACKET_WIDTH  stream word.
REQ-012 m_axis_tlast  output  1  marks the final word of a frame.
REQ-013 m_axis_tready  input  1  downstream accepts the word.
REQ-014 num_packets  output  addr_bits+1  packet count of the frame most recently closed by tick.
REQ-015 drain_overrun  output  1  sticky error flag: a tick arrived before the previous frame finished draining.

Function
REQ-016 FSM states SHALL be COLLECT, DRAIN_REQ and DRAIN.
- COLLECT: accept packets.
- DRAIN_REQ: one-cycle buffer read setup.
- DRAIN: stream words out.
REQ-017 In COLLECT, packet_in_ready SHALL be 1 iff wr_count < NUMBER_OF_OUTPUT_WORDS.
REQ-018 A transfer SHALL occur on packet_in_valid && packet_in_ready; it SHALL write packet_in at wr_count and increment wr_count by 1.
REQ-019 On tick in COLLECT, including a tick coincident with a transfer, the transfer SHALL be included in the frame.
- num_packets SHALL then load the final wr_count.
- If that count is nonzero, the FSM SHALL enter DRAIN_REQ; otherwise it SHALL stay in COLLECT.
- No stream output SHALL occur for an empty frame.
REQ-020 In DRAIN_REQ and DRAIN, packet_in_ready SHALL be 0; upstream SHALL hold its packets.
REQ-021 m_axis_tvalid SHALL assert no later than 2 cycles after the closing tick.
- Words SHALL be emitted in write order, addresses 0 .. num_packets-1.
REQ-022 While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast SHALL remain stable.
- m_axis_tvalid SHALL NOT deassert in that condition.
REQ-023 With m_axis_tready held 1, one word SHALL transfer per cycle with no bubbles.
REQ-024 m_axis_tlast SHALL be 1 only on the word at address num_packets-1.
REQ-025 After the tlast handshake, the following SHALL all happen on the next cycle:
- wr_count SHALL clear to 0.
- m_axis_tvalid SHALL drop.
- The FSM SHALL return to COLLECT.
REQ-026 A tick in DRAIN_REQ or DRAIN SHALL set drain_overrun.
- The drain SHALL continue unaffected.
- The tick SHALL otherwise be ignored.
REQ-027 drain_overrun SHALL clear only on reset.
REQ-028 A full buffer SHALL never be overwritten; excess packets SHALL stall via packet_in_ready=0, never drop silently.
REQ-029 Counters SHALL never wrap: wr_count saturates at NUMBER_OF_OUTPUT_WORDS by REQ-017.

Reset
REQ-030 While rst_n=0, the following SHALL hold asynchronously:
- The FSM SHALL be in COLLECT.
- wr_count, rd_addr and num_packets SHALL be 0.
- drain_overrun SHALL be 0.
- m_axis_tvalid and m_axis_tlast SHALL be 0.
- packet_in_ready SHALL be 0.
REQ-031 packet_in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset mid-DRAIN SHALL abandon the frame with no further stream words; buffer contents need not be cleared.
REQ-033 m_axis_tdata SHALL reset to 0.

Structure
REQ-034 A shared package SHALL hold:
- the clogb2 function;
- the FSM state encodings (COLLECT=2'b00, DRAIN_REQ=2'b01, DRAIN=2'b10).
REQ-035 The buffer SHALL be one sub-module, packet_buffer.
- Simple dual-port: 1 write port, 1 read port.
- Synchronous read with 1-cycle latency.
- No reset on its storage.
REQ-036 A one-entry output holding register SHALL implement REQ-022/023 in front of the read port.

Verification
REQ-037 Write 3 packets (0xA1, 0xA2, 0xA3), then tick, with tready=1 -> stream A1, A2, A3 on consecutive cycles, tlast on A3 only, num_packets=3.
REQ-038 Tick with no packets written -> m_axis_tvalid stays 0 and num_packets=0.
REQ-039 Hold packet_in_valid for 40 cycles with depth 32 -> 32 packets accepted, packet_in_ready=0 from the 33rd; after tick, 32 words stream out, last word tagged tlast.
REQ-040 Toggle tready 1,0,0,1 during a 4-word drain -> tdata stable through the stall, all 4 words delivered once each, in order.
REQ-041 Tick during DRAIN -> drain_overrun=1 and the drain completes intact; rst_n pulsed low mid-drain -> tvalid=0 immediately and the next frame starts at address 0.
REQ-042 Packet transfer coincident with tick -> that packet is the last word (tlast) of the frame.
